// File: rtl/psum_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psum_acc_pkg
// Description : Shared FSM encodings and SRAM strobe polarities for the
//               partial-sum accumulation controller.
// Revision    : 1.0 - initial release
// ============================================================================
package psum_acc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_ACC  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic SRAM_CEN_ON  = 1'b0;
    localparam logic SRAM_CEN_OFF = 1'b1;
    localparam logic SRAM_WEN_WR  = 1'b0;
    localparam logic SRAM_WEN_RD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/psum_acc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : psum_acc_ctrl_if
// Description : Job control, OFIFO drain and psum SRAM signals of the
//               accumulation controller; master = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface psum_acc_ctrl_if #(
    parameter int PSUM_BW    = 16,
    parameter int COL        = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                      start_i;
    logic                      ofifo_valid_i;
    logic [COL*PSUM_BW-1:0]    ofifo_data_i;
    logic                      ofifo_rd_o;
    logic                      psum_cen_o;
    logic                      psum_wen_o;
    logic [ADDR_WIDTH-1:0]     psum_addr_o;
    logic [COL*PSUM_BW-1:0]    psum_wdata_o;
    logic [COL*PSUM_BW-1:0]    psum_rdata_i;
    logic                      busy_o;
    logic [3:0]                kij_o;
    logic                      done_o;

    modport master (
        input  start_i, ofifo_valid_i, ofifo_data_i, psum_rdata_i,
        output ofifo_rd_o, psum_cen_o, psum_wen_o, psum_addr_o, psum_wdata_o,
               busy_o, kij_o, done_o
    );

    modport slave (
        output start_i, ofifo_valid_i, ofifo_data_i, psum_rdata_i,
        input  ofifo_rd_o, psum_cen_o, psum_wen_o, psum_addr_o, psum_wdata_o,
               busy_o, kij_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/psum_lane_add.sv
`default_nettype none
// ============================================================================
// Module      : psum_lane_add
// Description : One psum lane: wrap-around signed add with optional clamp of
//               negative results to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_lane_add #(
    parameter int PSUM_BW = 16
) (
    input  wire logic [PSUM_BW-1:0] a,
    input  wire logic [PSUM_BW-1:0] b,
    input  wire logic               relu_en,
    output logic      [PSUM_BW-1:0] sum
);
    logic [PSUM_BW-1:0] w_raw;

    assign w_raw = a + b;
    assign sum   = (relu_en && w_raw[PSUM_BW-1]) ? '0 : w_raw;
endmodule
`default_nettype wire

// File: rtl/psum_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : psum_acc_ctrl
// Description : Drains OFIFO rows and read-modify-writes them into the psum
//               SRAM over NUM_KIJ kernel passes. Optional macro
//               PSUM_ACC_RELU_EN clamps negative lanes on the final pass.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_acc_ctrl
    import psum_acc_pkg::*;
#(
    parameter int PSUM_BW    = 16,
    parameter int COL        = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_ONIJ   = 16,
    parameter int NUM_KIJ    = 9
) (
    input  wire logic        clk,
    input  wire logic        reset,
    psum_acc_ctrl_if.master  bus
);
    localparam int                    W           = COL * PSUM_BW;
    localparam logic [ADDR_WIDTH-1:0] C_LAST_ONIJ = ADDR_WIDTH'(LEN_ONIJ - 1);
    localparam logic [3:0]            C_LAST_KIJ  = 4'(NUM_KIJ - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_onij;
    logic [3:0]            r_kij;
    logic [W-1:0]          r_row;
    logic                  r_cen;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [W-1:0]          r_wdata;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_in_acc;
    logic                  w_relu_en;
    logic [W-1:0]          w_add_a;
    logic [W-1:0]          w_add_b;
    logic [W-1:0]          w_sum;

    // Pass 0 reuses the adder with a zero operand so the clamp also covers a
    // single-pass job.
    assign w_in_acc = (r_state == ST_ACC);
    assign w_add_a  = w_in_acc ? bus.psum_rdata_i : '0;
    assign w_add_b  = w_in_acc ? r_row : bus.ofifo_data_i;

`ifdef PSUM_ACC_RELU_EN
    assign w_relu_en = (r_kij == C_LAST_KIJ);
`else
    assign w_relu_en = 1'b0;
`endif

    generate
        for (genvar g = 0; g < COL; g++) begin : g_lane
            psum_lane_add #(.PSUM_BW(PSUM_BW)) u_add (
                .a       (w_add_a[g*PSUM_BW +: PSUM_BW]),
                .b       (w_add_b[g*PSUM_BW +: PSUM_BW]),
                .relu_en (w_relu_en),
                .sum     (w_sum[g*PSUM_BW +: PSUM_BW])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_onij  <= '0;
            r_kij   <= '0;
            r_row   <= '0;
            r_cen   <= SRAM_CEN_OFF;
            r_wen   <= SRAM_WEN_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cen  <= SRAM_CEN_OFF;
            r_wen  <= SRAM_WEN_RD;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_state <= ST_POP;
                        r_onij  <= '0;
                        r_kij   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_POP: begin
                    if (bus.ofifo_valid_i) begin
                        r_row  <= bus.ofifo_data_i;
                        r_addr <= r_onij;
                        r_cen  <= SRAM_CEN_ON;
                        if (r_kij == 4'd0) begin
                            r_wdata <= w_sum;
                            r_wen   <= SRAM_WEN_WR;
                            r_state <= ST_WR;
                        end else begin
                            r_wen   <= SRAM_WEN_RD;
                            r_state <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    r_row   <= w_sum;
                    r_wdata <= w_sum;
                    r_cen   <= SRAM_CEN_ON;
                    r_wen   <= SRAM_WEN_WR;
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    if (r_onij < C_LAST_ONIJ) begin
                        r_onij  <= r_onij + 1'b1;
                        r_state <= ST_POP;
                    end else begin
                        r_onij <= '0;
                        if (r_kij == C_LAST_KIJ) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_kij   <= r_kij + 1'b1;
                            r_state <= ST_POP;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ofifo_rd_o   = (r_state == ST_POP) & bus.ofifo_valid_i;
    assign bus.psum_cen_o   = r_cen;
    assign bus.psum_wen_o   = r_wen;
    assign bus.psum_addr_o  = r_addr;
    assign bus.psum_wdata_o = r_wdata;
    assign bus.busy_o       = r_busy;
    assign bus.kij_o        = r_kij;
    assign bus.done_o       = r_done;
endmodule
`default_nettype wire
